// File: rtl/tx_ethernet.sv
// tx_ethernet: GMII Ethernet II frame transmitter with zero pad, CRC-32 FCS and inter-frame gap
module tx_ethernet #(
  parameter int PRE_BYTES   = 7,
  parameter int MIN_PAYLOAD = 46,
  parameter int MAX_PAYLOAD = 1500,
  parameter int IFG_BYTES   = 12
) (
  input  logic        TX_CLK,
  input  logic        rst,
  input  logic [47:0] dst_mac,
  input  logic [47:0] src_mac,
  input  logic [15:0] ethertype,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  input  logic        tx_last,
  output logic        tx_ready,
  output logic        TX_EN,
  output logic [7:0]  TXD,
  output logic        TX_ER,
  output logic        busy,
  output logic        frame_done,
  output logic        tx_abort,
  output logic        GTX_CLK
);
  typedef enum logic [3:0] {IDLE, PRE, SFD, HDR, PAY, PAD, FCS, ERR, IFG} state_t;
  state_t        state_q, state_d;
  logic [10:0]   cnt_q, cnt_d;
  logic [111:0]  hdr_q, hdr_d;
  logic [31:0]   crc_q, crc_d;
  logic [31:0]   fcs;
  logic          tx_en_d, tx_er_d, pend_q, pend_d;
  logic [7:0]    txd_d;
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction
  assign fcs      = ~crc_q;
  assign tx_ready = state_q == PAY;
  assign busy     = state_q != IDLE;
  assign GTX_CLK  = TX_CLK;
  // Next-state, CRC accumulation and the GMII byte to register; outputs lag state by one cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hdr_d   = hdr_q;
    crc_d   = crc_q;
    tx_en_d = 1'b1;
    tx_er_d = 1'b0;
    txd_d   = 8'h00;
    pend_d  = 1'b0;
    case (state_q)
      IDLE: begin
        tx_en_d = 1'b0;
        crc_d   = '1;
        cnt_d   = '0;
        if (tx_valid) begin
          hdr_d   = {dst_mac, src_mac, ethertype};
          state_d = PRE;
        end
      end
      PRE: begin
        txd_d   = 8'h55;
        cnt_d   = int'(cnt_q) == PRE_BYTES - 1 ? '0 : cnt_q + 11'd1;
        state_d = int'(cnt_q) == PRE_BYTES - 1 ? SFD : PRE;
      end
      SFD: begin
        txd_d   = 8'hD5;
        state_d = HDR;
      end
      HDR: begin
        txd_d   = hdr_q[111:104];
        hdr_d   = hdr_q << 8;
        crc_d   = crc_byte(crc_q, hdr_q[111:104]);
        cnt_d   = cnt_q == 11'd13 ? '0 : cnt_q + 11'd1;
        state_d = cnt_q == 11'd13 ? PAY : HDR;
      end
      PAY: begin
        if (tx_valid) begin
          txd_d = tx_data;
          crc_d = crc_byte(crc_q, tx_data);
          cnt_d = tx_last && int'(cnt_q) + 1 >= MIN_PAYLOAD ? '0 : cnt_q + 11'd1;
          if (tx_last) state_d = int'(cnt_q) + 1 < MIN_PAYLOAD ? PAD : FCS;
          else if (int'(cnt_q) == MAX_PAYLOAD - 1) state_d = ERR;
        end else begin
          tx_er_d = 1'b1;
          cnt_d   = '0;
          state_d = IFG;
        end
      end
      PAD: begin
        crc_d   = crc_byte(crc_q, 8'h00);
        cnt_d   = int'(cnt_q) == MIN_PAYLOAD - 1 ? '0 : cnt_q + 11'd1;
        state_d = int'(cnt_q) == MIN_PAYLOAD - 1 ? FCS : PAD;
      end
      FCS: begin
        txd_d   = fcs[{cnt_q[1:0], 3'b000} +: 8];
        pend_d  = cnt_q == 11'd3;
        cnt_d   = cnt_q == 11'd3 ? '0 : cnt_q + 11'd1;
        state_d = cnt_q == 11'd3 ? IFG : FCS;
      end
      ERR: begin
        tx_er_d = 1'b1;
        cnt_d   = '0;
        state_d = IFG;
      end
      IFG: begin
        tx_en_d = 1'b0;
        crc_d   = '1;
        cnt_d   = int'(cnt_q) == IFG_BYTES - 2 ? '0 : cnt_q + 11'd1;
        state_d = int'(cnt_q) == IFG_BYTES - 2 ? IDLE : IFG;
      end
      default: begin
        tx_en_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  // State and registered GMII outputs; async reset drops TX_EN at once
  always_ff @(posedge TX_CLK or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hdr_q      <= '0;
      crc_q      <= '1;
      pend_q     <= 1'b0;
      TX_EN      <= 1'b0;
      TXD        <= 8'h00;
      TX_ER      <= 1'b0;
      tx_abort   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hdr_q      <= hdr_d;
      crc_q      <= crc_d;
      pend_q     <= pend_d;
      TX_EN      <= tx_en_d;
      TXD        <= txd_d;
      TX_ER      <= tx_er_d;
      tx_abort   <= tx_er_d;
      frame_done <= pend_q;
    end
  end
endmodule
